// File: rtl/red_pitaya_calib_pkg.sv
// Shared types and helpers for the ADC calibration datapath.
// Gain is Q(DWM-2): unity = 1 << (DWM-2).
package red_pitaya_calib_pkg;

    localparam int CALIB_DWM = 16;
    localparam int CALIB_DWS = 14;

    typedef struct packed {
        logic signed [CALIB_DWM-1:0] mul;
        logic signed [CALIB_DWS-1:0] sum;
    } calib_cfg_t;

    function automatic logic [31:0] calib_unity(input int dwm);
        return 32'd1 << (dwm - 2);
    endfunction

    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/red_pitaya_sat_cnt.sv
// Sticky saturation flag plus saturating event counter.
// A clear in the same cycle as an event keeps that event.
module red_pitaya_sat_cnt
    import red_pitaya_calib_pkg::*;
#(
    parameter int DWC = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           evt,
    input  logic           clr,
    output logic           flg,
    output logic [DWC-1:0] cnt
);

    logic           flg_q, flg_d;
    logic [DWC-1:0] cnt_q, cnt_d;

    always_comb begin
        flg_d = flg_q;
        cnt_d = cnt_q;
        if (clr) begin
            flg_d = evt;
            cnt_d = evt ? DWC'(1) : '0;
        end else if (evt) begin
            flg_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + DWC'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            flg_q <= flg_d;
            cnt_q <= cnt_d;
        end
    end

    assign flg = flg_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/red_pitaya_adc_calib_proc.sv
// Streaming ADC calibration: y = sat(((x + sum) * mul) >>> (DWM-2)).
// Three stages under one global stall (en), gain carried with stage-1 data.
module red_pitaya_adc_calib_proc
    import red_pitaya_calib_pkg::*;
#(
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int DWM = 16,
    parameter int DWS = 14,
    parameter int DWC = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [DWM-1:0] cfg_mul,
    input  logic [DWS-1:0] cfg_sum,
    input  logic           cfg_load,
    input  logic [DWI-1:0] sti_dat,
    input  logic           sti_vld,
    output logic           sti_rdy,
    output logic [DWO-1:0] sto_dat,
    output logic           sto_vld,
    input  logic           sto_rdy,
    output logic           sat_flg,
    output logic [DWC-1:0] sat_cnt,
    input  logic           sat_clr
);

    localparam int DWU = DWI + 1;
    localparam int DWP = DWI + 1 + DWM;

    logic en;

    calib_cfg_t act_q, act_d;

    logic                  s1_vld_q, s1_vld_d;
    logic signed [DWU-1:0] s1_dat_q, s1_dat_d;
    logic signed [DWM-1:0] s1_mul_q, s1_mul_d;
    logic                  s2_vld_q, s2_vld_d;
    logic signed [DWP-1:0] s2_dat_q, s2_dat_d;
    logic                  s3_vld_q, s3_vld_d;
    logic signed [DWO-1:0] s3_dat_q, s3_dat_d;

    logic signed [DWP-1:0] s3_shf;
    logic signed [63:0]    s3_wide;
    logic signed [63:0]    s3_clp;
    logic                  sat_evt;

    always_comb begin
        en = ~s3_vld_q | sto_rdy;

        // New coefficients apply to samples entering after the load edge.
        act_d = act_q;
        if (cfg_load) begin
            act_d.mul = cfg_mul;
            act_d.sum = cfg_sum;
        end

        s3_shf  = s2_dat_q >>> (DWM - 2);
        s3_wide = 64'(s3_shf);
        s3_clp  = sat_clamp(s3_wide, DWO);
        sat_evt = en & s2_vld_q & (s3_clp != s3_wide);

        s1_vld_d = s1_vld_q;
        s1_dat_d = s1_dat_q;
        s1_mul_d = s1_mul_q;
        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        s3_vld_d = s3_vld_q;
        s3_dat_d = s3_dat_q;

        if (en) begin
            s1_vld_d = sti_vld;
            s1_dat_d = DWU'($signed(sti_dat)) + DWU'(act_q.sum);
            s1_mul_d = act_q.mul;
            s2_vld_d = s1_vld_q;
            s2_dat_d = DWP'(s1_dat_q) * DWP'(s1_mul_q);
            s3_vld_d = s2_vld_q;
            if (s2_vld_q) s3_dat_d = DWO'(s3_clp);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q.mul <= DWM'(calib_unity(DWM));
            act_q.sum <= '0;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_mul_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_dat_q  <= '0;
        end else begin
            act_q    <= act_d;
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
            s1_mul_q <= s1_mul_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            s3_vld_q <= s3_vld_d;
            s3_dat_q <= s3_dat_d;
        end
    end

    red_pitaya_sat_cnt #(
        .DWC (DWC)
    ) u_sat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .evt  (sat_evt),
        .clr  (sat_clr),
        .flg  (sat_flg),
        .cnt  (sat_cnt)
    );

    assign sti_rdy = en;
    assign sto_dat = s3_dat_q;
    assign sto_vld = s3_vld_q;

endmodule

// File: tb/tb_red_pitaya_adc_calib_proc.sv
// Scoreboard bench for red_pitaya_adc_calib_proc.
// Expected samples are queued at input transfer and popped at output transfer.
module tb_red_pitaya_adc_calib_proc;

    logic               clk = 1'b0;
    logic               rstn;
    logic signed [15:0] cfg_mul;
    logic signed [13:0] cfg_sum;
    logic               cfg_load;
    logic signed [13:0] sti_dat;
    logic               sti_vld;
    logic               sti_rdy;
    logic signed [13:0] sto_dat;
    logic               sto_vld;
    logic               sto_rdy;
    logic               sat_flg;
    logic [15:0]        sat_cnt;
    logic               sat_clr;

    int total = 0;
    int bad   = 0;

    int sb[$];
    int out_log[$];
    int m_mul = 16384;
    int m_sum = 0;
    int last_out = 0;
    bit prev_stall = 0;
    int prev_dat = 0;

    always #5 clk = ~clk;

    red_pitaya_adc_calib_proc dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_mul  (cfg_mul),
        .cfg_sum  (cfg_sum),
        .cfg_load (cfg_load),
        .sti_dat  (sti_dat),
        .sti_vld  (sti_vld),
        .sti_rdy  (sti_rdy),
        .sto_dat  (sto_dat),
        .sto_vld  (sto_vld),
        .sto_rdy  (sto_rdy),
        .sat_flg  (sat_flg),
        .sat_cnt  (sat_cnt),
        .sat_clr  (sat_clr)
    );

    function automatic int model(input int x);
        longint p;
        longint q;
        p = longint'(x + m_sum) * longint'(m_mul);
        q = p / 16384;
        if (p < 0 && (p % 16384) != 0) q = q - 1;
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
        return int'(q);
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            m_mul = 16384;
            m_sum = 0;
            prev_stall = 0;
        end else begin
            if (sto_vld && sto_rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow got=%0d exp=none", sto_dat);
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (int'(sto_dat) !== e) begin
                        bad++;
                        $display("FAIL sb_data got=%0d exp=%0d", sto_dat, e);
                    end
                end
                last_out = int'(sto_dat);
                out_log.push_back(int'(sto_dat));
            end
            if (prev_stall) begin
                total++;
                if (sto_vld !== 1'b1 || int'(sto_dat) !== prev_dat) begin
                    bad++;
                    $display("FAIL stall_hold got=%0d/%0d exp=1/%0d",
                             sto_vld, sto_dat, prev_dat);
                end
            end
            prev_stall = sto_vld && !sto_rdy;
            prev_dat   = int'(sto_dat);
            if (sti_vld && sti_rdy) sb.push_back(model(int'(sti_dat)));
            if (cfg_load) begin
                m_mul = int'(cfg_mul);
                m_sum = int'(cfg_sum);
            end
        end
    end

    task automatic put(input int x);
        bit ok;
        ok = 0;
        sti_dat = 14'(x);
        sti_vld = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (sti_rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL put_timeout got=rdy0 exp=rdy1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        put(x);
        sti_vld = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (sb.size() == 0 && !sto_vld) break;
        end
        total++;
        if (sb.size() != 0 || sto_vld) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int mul, input int sum);
        cfg_mul  = 16'(mul);
        cfg_sum  = 14'(sum);
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (sto_vld !== 1'b0 || sto_dat !== 14'sd0) begin
            bad++;
            $display("FAIL reset_out got=%0d/%0d exp=0/0", sto_vld, sto_dat);
        end
        total++;
        if (sat_flg !== 1'b0 || sat_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_sat got=%0d/%0d exp=0/0", sat_flg, sat_cnt);
        end
        total++;
        if (sti_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy got=%0d exp=1", sti_rdy);
        end
        send(1000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (sto_vld !== (i == 3)) begin
                bad++;
                $display("FAIL latency_c%0d got=%0d exp=%0d", i, sto_vld, i == 3);
            end
        end
        total++;
        if (sto_dat !== 14'sd1000) begin
            bad++;
            $display("FAIL passthru got=%0d exp=1000", sto_dat);
        end
        drain();
        total++;
        if (sat_flg !== 1'b0) begin
            bad++;
            $display("FAIL passthru_flg got=%0d exp=0", sat_flg);
        end
    endtask

    task automatic test_offset();
        load_cfg(16384, -200);
        send(-100);
        drain();
        total++;
        if (last_out !== -300 || sat_flg !== 1'b0) begin
            bad++;
            $display("FAIL offset got=%0d/%0d exp=-300/0", last_out, sat_flg);
        end
        send(-8100);
        drain();
        total++;
        if (last_out !== -8192) begin
            bad++;
            $display("FAIL offset_clamp got=%0d exp=-8192", last_out);
        end
        total++;
        if (sat_flg !== 1'b1 || sat_cnt !== 16'd1) begin
            bad++;
            $display("FAIL offset_sat got=%0d/%0d exp=1/1", sat_flg, sat_cnt);
        end
    endtask

    task automatic test_gain();
        load_cfg(32767, 0);
        send(-5000);
        drain();
        total++;
        if (last_out !== -8192) begin
            bad++;
            $display("FAIL gain_neg got=%0d exp=-8192", last_out);
        end
        send(3000);
        drain();
        total++;
        if (last_out !== 5999) begin
            bad++;
            $display("FAIL gain_pos got=%0d exp=5999", last_out);
        end
        total++;
        if (sat_cnt !== 16'd2) begin
            bad++;
            $display("FAIL gain_cnt got=%0d exp=2", sat_cnt);
        end
    endtask

    task automatic test_backpressure();
        int  base;
        bit  done;
        done = 0;
        load_cfg(16384, 0);
        base = out_log.size();
        fork
            begin
                for (int i = 0; i < 100; i++) put(i);
                sti_vld = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    sto_rdy = 1'($urandom_range(0, 1));
                end
                sto_rdy = 1'b1;
            end
        join
        drain();
        total++;
        if (out_log.size() - base !== 100) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=100", out_log.size() - base);
        end else begin
            for (int i = 0; i < 100; i++) begin
                total++;
                if (out_log[base + i] !== i) begin
                    bad++;
                    $display("FAIL bp_ramp got=%0d exp=%0d", out_log[base + i], i);
                end
            end
        end
    endtask

    task automatic test_cfg_midstream();
        int base;
        base = out_log.size();
        cfg_mul = 16'sd8192;
        cfg_sum = 14'sd0;
        for (int i = 0; i < 20; i++) begin
            sti_dat  = 14'(100 + i);
            sti_vld  = 1'b1;
            cfg_load = (i == 10);
            @(posedge clk);
            #1;
        end
        sti_vld  = 1'b0;
        cfg_load = 1'b0;
        drain();
        total++;
        if (out_log.size() - base !== 20) begin
            bad++;
            $display("FAIL mid_count got=%0d exp=20", out_log.size() - base);
        end else begin
            total++;
            if (out_log[base + 9] !== 109 || out_log[base + 10] !== 110) begin
                bad++;
                $display("FAIL mid_before got=%0d,%0d exp=109,110",
                         out_log[base + 9], out_log[base + 10]);
            end
            total++;
            if (out_log[base + 11] !== 55 || out_log[base + 19] !== 59) begin
                bad++;
                $display("FAIL mid_after got=%0d,%0d exp=55,59",
                         out_log[base + 11], out_log[base + 19]);
            end
        end
    endtask

    task automatic test_sat_cnt();
        load_cfg(32767, 0);
        sti_dat = -14'sd8000;
        sti_vld = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        sti_vld = 1'b0;
        drain();
        total++;
        if (sat_cnt !== 16'hffff || sat_flg !== 1'b1) begin
            bad++;
            $display("FAIL cnt_stop got=%0d/%0d exp=65535/1", sat_cnt, sat_flg);
        end
        for (int i = 0; i < 20; i++) begin
            sti_dat = -14'sd8000;
            sti_vld = 1'b1;
            sat_clr = (i == 10);
            @(posedge clk);
            #1;
            if (i == 10) begin
                total++;
                if (sat_cnt !== 16'd1 || sat_flg !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_evt got=%0d/%0d exp=1/1", sat_cnt, sat_flg);
                end
            end
        end
        sti_vld = 1'b0;
        sat_clr = 1'b0;
        drain();
        total++;
        if (sat_cnt !== 16'd12) begin
            bad++;
            $display("FAIL clr_after got=%0d exp=12", sat_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) begin
            sti_dat = 14'sd100;
            sti_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (sto_vld !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got=%0d exp=1", sto_vld);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (sto_vld !== 1'b0 || sat_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_async got=%0d/%0d exp=0/0", sto_vld, sat_cnt);
        end
        sti_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(1234);
        drain();
        total++;
        if (last_out !== 1234) begin
            bad++;
            $display("FAIL rst_passthru got=%0d exp=1234", last_out);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        cfg_mul  = 16'sd16384;
        cfg_sum  = 14'sd0;
        cfg_load = 1'b0;
        sti_dat  = 14'sd0;
        sti_vld  = 1'b0;
        sto_rdy  = 1'b1;
        sat_clr  = 1'b0;
        #23;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_offset();
        test_gain();
        test_backpressure();
        test_cfg_midstream();
        test_sat_cnt();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
